// File: rtl/inst_axi_bridge_pkg.sv
// Shared constants for the instruction-side AXI read bridge: FSM encodings,
// AXI code points and the bus word width.
package inst_axi_bridge_pkg;

    localparam int SINGLE_WORD = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AR   = 2'd1;
    localparam logic [1:0] S_R    = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/inst_axi_bridge_line_assembler.sv
// Collects the R-channel beats of one burst into a fetch line and accumulates
// the bus-error flag (bad rresp or rlast on the wrong beat).
module inst_axi_bridge_line_assembler
    import inst_axi_bridge_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         beat,
    input  logic                         last,
    input  logic [SINGLE_WORD-1:0]       rdata,
    input  logic [1:0]                   rresp,
    output logic [SINGLE_WORD*WORDS-1:0] line,
    output logic                         err
);

    localparam int CW = $clog2(WORDS);

    logic [CW-1:0]    cnt;
    logic [WORDS-1:0] slot_we;

    always_comb begin
        slot_we = '0;
        for (int i = 0; i < WORDS; i++) begin
            slot_we[i] = beat && (cnt == CW'(i));
        end
    end

    // NOTE: the line register has an explicit reset because the fetch side may
    // observe inst_rdata at any time; it is not cleared between requests.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line <= '0;
        end else begin
            for (int i = 0; i < WORDS; i++) begin
                if (slot_we[i]) line[i*SINGLE_WORD +: SINGLE_WORD] <= rdata;
            end
        end
    end

    // The counter wraps, so an over-long burst still lands somewhere in the line
    // and is flagged by the rlast position check.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else if (clear) begin
            cnt <= '0;
            err <= 1'b0;
        end else if (beat) begin
            cnt <= cnt + 1'b1;
            err <= err || (rresp != AXI_RESP_OKAY) || (last && (cnt != CW'(WORDS - 1)));
        end
    end

endmodule

// File: rtl/inst_axi_bridge.sv
// Instruction fetch bridge: one line request at a time becomes a single AXI
// INCR read burst; cancelled requests drain their burst without a response.
module inst_axi_bridge
    import inst_axi_bridge_pkg::*;
#(
    parameter int         WORDS  = 4,
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         inst_req,
    input  logic [31:0]                  inst_addr,
    input  logic                         inst_cancel,
    output logic                         inst_addr_ok,
    output logic                         inst_data_ok,
    output logic [SINGLE_WORD*WORDS-1:0] inst_rdata,
    output logic                         inst_bus_err,
    output logic [3:0]                   arid,
    output logic [31:0]                  araddr,
    output logic [7:0]                   arlen,
    output logic [2:0]                   arsize,
    output logic [1:0]                   arburst,
    output logic                         arvalid,
    input  logic                         arready,
    input  logic [3:0]                   rid,
    input  logic [31:0]                  rdata,
    input  logic [1:0]                   rresp,
    input  logic                         rlast,
    input  logic                         rvalid,
    output logic                         rready
);

    localparam logic [31:0] LINE_MASK = 32'(WORDS * 4 - 1);

    logic [1:0] state;
    logic       drop;
    logic       accept;
    logic       beat;
    logic       err;
    logic       unused_rid;

    assign unused_rid = ^rid;

    assign arid    = AXI_ID;
    assign arlen   = 8'(WORDS - 1);
    assign arsize  = AXI_SIZE_4B;
    assign arburst = AXI_BURST_INCR;

    assign accept       = (state == S_IDLE) && inst_req;
    assign beat         = (state == S_R) && rvalid;
    assign inst_addr_ok = accept;
    assign arvalid      = (state == S_AR);
    assign rready       = (state == S_R);
    assign inst_data_ok = (state == S_RESP);
    assign inst_bus_err = (state == S_RESP) && err;

    // A cancel arriving with the rlast beat must already count as a drop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            drop   <= 1'b0;
            araddr <= '0;
        end else begin
            case (state)
                S_IDLE: if (inst_req) begin
                    araddr <= inst_addr & ~LINE_MASK;
                    drop   <= 1'b0;
                    state  <= S_AR;
                end
                S_AR: begin
                    if (inst_cancel) drop <= 1'b1;
                    if (arready) state <= S_R;
                end
                S_R: begin
                    if (inst_cancel) drop <= 1'b1;
                    if (rvalid && rlast) state <= (drop || inst_cancel) ? S_IDLE : S_RESP;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    inst_axi_bridge_line_assembler #(.WORDS(WORDS)) u_line (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .beat  (beat),
        .last  (rlast),
        .rdata (rdata),
        .rresp (rresp),
        .line  (inst_rdata),
        .err   (err)
    );

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Directed-plus-random bench for inst_axi_bridge: the bench plays the AXI slave
// and predicts each line, error flag and response pulse from the fetch rules.
module tb_inst_axi_bridge;

    localparam int WORDS = 4;
    localparam int LW    = 32 * WORDS;

    localparam int CK_NONE   = 0;
    localparam int CK_ACCEPT = 1;
    localparam int CK_AR     = 2;
    localparam int CK_BEAT   = 3;
    localparam int CK_LAST   = 4;
    localparam int CK_RESP   = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          inst_req = 1'b0;
    logic [31:0]   inst_addr = '0;
    logic          inst_cancel = 1'b0;
    logic          inst_addr_ok;
    logic          inst_data_ok;
    logic [LW-1:0] inst_rdata;
    logic          inst_bus_err;
    logic [3:0]    arid;
    logic [31:0]   araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid;
    logic          arready = 1'b0;
    logic [3:0]    rid = 4'hA;
    logic [31:0]   rdata = '0;
    logic [1:0]    rresp = '0;
    logic          rlast = 1'b0;
    logic          rvalid = 1'b0;
    logic          rready;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_words [WORDS];

    always #5 clk = ~clk;

    inst_axi_bridge #(.WORDS(WORDS), .AXI_ID(4'd5)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_cancel  (inst_cancel),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .inst_bus_err (inst_bus_err),
        .arid         (arid),
        .araddr       (araddr),
        .arlen        (arlen),
        .arsize       (arsize),
        .arburst      (arburst),
        .arvalid      (arvalid),
        .arready      (arready),
        .rid          (rid),
        .rdata        (rdata),
        .rresp        (rresp),
        .rlast        (rlast),
        .rvalid       (rvalid),
        .rready       (rready)
    );

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] exp_line();
        logic [LW-1:0] l;
        for (int i = 0; i < WORDS; i++) l[i*32 +: 32] = exp_words[i];
        return l;
    endfunction

    // One complete fetch as seen by the slave. Returns in the first cycle in
    // which a new request may be accepted.
    task automatic run_fetch(input logic [31:0] addr, input int ar_wait, input int max_gap,
                             input int err_beat, input int last_beat, input int ck,
                             input int ck_beat, input bit fixed);
        logic [31:0] aligned;
        bit          dropped;
        bit          err;
        int          gap;
        aligned = addr & ~32'(WORDS * 4 - 1);
        dropped = (ck == CK_AR) || (ck == CK_BEAT) || (ck == CK_LAST);
        err     = (last_beat != WORDS - 1);

        inst_req = 1'b1; inst_addr = addr; inst_cancel = (ck == CK_ACCEPT);
        #1;
        check("accept_addr_ok", inst_addr_ok, 1);
        check("idle_data_ok", inst_data_ok, 0);
        step();
        inst_req = 1'b0; inst_cancel = 1'b0;

        for (int w = 0; w <= ar_wait; w++) begin
            inst_req    = (w < ar_wait);
            arready     = (w == ar_wait);
            inst_cancel = (ck == CK_AR) && (w == ar_wait);
            #1;
            check("ar_valid", arvalid, 1);
            check("ar_addr", araddr, aligned);
            check("ar_busy_addr_ok", inst_addr_ok, 0);
            step();
        end
        arready = 1'b0; inst_cancel = 1'b0; inst_req = 1'b0;

        for (int b = 0; b <= last_beat; b++) begin
            gap = int'($urandom_range(0, max_gap));
            repeat (gap) begin
                #1; check("r_gap_ready", rready, 1);
                step();
            end
            rvalid      = 1'b1;
            rdata       = fixed ? 32'((b + 1) * 17) : $urandom;
            rresp       = (b == err_beat) ? 2'b10 : 2'b00;
            rlast       = (b == last_beat);
            inst_cancel = (ck == CK_LAST) && (b == last_beat);
            exp_words[b % WORDS] = rdata;
            if (rresp != 2'b00) err = 1'b1;
            #1; check("r_beat_ready", rready, 1);
            step();
            rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; inst_cancel = 1'b0;
            if (ck == CK_BEAT && b == ck_beat) begin
                inst_cancel = 1'b1;
                #1; check("r_cancel_ready", rready, 1);
                step();
                inst_cancel = 1'b0;
            end
        end

        inst_cancel = (ck == CK_RESP);
        #1;
        if (!dropped) begin
            check("resp_data_ok", inst_data_ok, 1);
            check("resp_rdata", inst_rdata, exp_line());
            check("resp_bus_err", inst_bus_err, err);
            step();
            inst_cancel = 1'b0;
        end else begin
            check("drop_no_data_ok", inst_data_ok, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int ck, ck_beat, last_beat, err_beat;
        for (int i = 0; i < WORDS; i++) exp_words[i] = '0;

        // Reset state
        #1;
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_data_ok", inst_data_ok, 0);
        check("rst_addr_ok", inst_addr_ok, 0);
        check("rst_bus_err", inst_bus_err, 0);
        check("rst_rdata", inst_rdata, 0);
        check("rst_araddr", araddr, 0);
        check("const_arid", arid, 4'd5);
        check("const_arlen", arlen, 8'd3);
        check("const_arsize", arsize, 3'b010);
        check("const_arburst", arburst, 2'b01);
        step(); step();
        rst = 1'b1;
        step();

        // Basic zero-wait fetch, then back-pressure
        run_fetch(32'h1FC0_0014, 0, 0, -1, WORDS - 1, CK_NONE, 0, 1'b1);
        check("basic_line", inst_rdata, 128'h00000044_00000033_00000022_00000011);
        run_fetch(32'h0000_1238, 3, 2, -1, WORDS - 1, CK_NONE, 0, 1'b0);

        // Cancel mid-burst, error response, early rlast
        run_fetch(32'h8000_0040, 1, 1, -1, WORDS - 1, CK_BEAT, 1, 1'b0);
        run_fetch(32'h8000_0050, 0, 1, 2, WORDS - 1, CK_NONE, 0, 1'b0);
        run_fetch(32'h8000_0060, 0, 0, -1, 2, CK_NONE, 0, 1'b0);

        // Edge cancels
        run_fetch(32'h0000_0100, 0, 1, -1, WORDS - 1, CK_ACCEPT, 0, 1'b0);
        run_fetch(32'h0000_0110, 0, 0, -1, WORDS - 1, CK_RESP, 0, 1'b0);
        run_fetch(32'h0000_0120, 1, 0, -1, WORDS - 1, CK_LAST, 0, 1'b0);
        run_fetch(32'h0000_0130, 2, 0, -1, WORDS - 1, CK_AR, 0, 1'b0);
        run_fetch(32'h0000_0140, 0, 0, -1, WORDS - 1, CK_NONE, 0, 1'b0);

        // Randomized mix
        for (int n = 0; n < 16; n++) begin
            ck        = int'($urandom_range(CK_NONE, CK_RESP));
            last_beat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WORDS - 2)) : WORDS - 1;
            err_beat  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WORDS - 1)) : -1;
            if (ck == CK_BEAT && last_beat == 0) ck = CK_NONE;
            ck_beat   = (ck == CK_BEAT) ? int'($urandom_range(0, last_beat - 1)) : 0;
            run_fetch($urandom, int'($urandom_range(0, 3)), 2, err_beat, last_beat, ck, ck_beat, 1'b0);
        end

        // Reset while in R
        inst_req = 1'b1; inst_addr = 32'h2000_0008;
        step();
        inst_req = 1'b0; arready = 1'b1;
        step();
        arready = 1'b0; rvalid = 1'b1; rdata = $urandom;
        step();
        rvalid = 1'b0;
        #1; check("pre_rst_rready", rready, 1);
        #2; rst = 1'b0;
        #1;
        check("mid_rst_arvalid", arvalid, 0);
        check("mid_rst_rready", rready, 0);
        check("mid_rst_data_ok", inst_data_ok, 0);
        check("mid_rst_araddr", araddr, 0);
        check("mid_rst_rdata", inst_rdata, 0);
        for (int i = 0; i < WORDS; i++) exp_words[i] = '0;
        step(); step();
        rst = 1'b1;
        step();
        run_fetch(32'h1FC0_0014, 0, 0, -1, WORDS - 1, CK_NONE, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
